// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  // Bulk-clear sequencer states.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DEF_WIDTH = 32;
  localparam int unsigned RF_DEF_DEPTH = 16;

  // A write lands only when the clear engine is idle, the address exists,
  // and it is not aimed at a hardwired-zero entry 0.
  function automatic logic rf_wr_accept(
    input logic        wr_en,
    input logic        idle,
    input int unsigned addr,
    input int unsigned depth,
    input logic        zero_reg
  );
    return wr_en && idle && (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between the CPU datapath (master) and the register file (slave).
interface reg_file_mp_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] rd_addr1;
  logic              rd_en1;
  logic [WIDTH-1:0]  rd_data1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_en2;
  logic [WIDTH-1:0]  rd_data2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr1, rd_en1, rd_addr2, rd_en2,
    output wr_en, wr_addr, wr_data, clr_req,
    input  rd_data1, rd_data2, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr1, rd_en1, rd_addr2, rd_en2,
    input  wr_en, wr_addr, wr_data, clr_req,
    output rd_data1, rd_data2, clr_busy, clr_done
  );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Bulk-clear sequencer: walks a pointer over every entry, one per cycle,
// and reports busy while walking and a one-cycle done afterwards.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter  int unsigned DEPTH  = RF_DEF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_req,
  output logic              o_idle,
  output logic              o_clr_busy,
  output logic              o_clr_done,
  output logic              o_clear_we,
  output logic [ADDR_W-1:0] o_clear_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  // State, pointer and handshake flops; reset aborts any clear silently.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RF_IDLE;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: start on clr_req from IDLE, finish after the last entry.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      RF_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      RF_CLEAR: begin
        if (r_ptr == LAST_PTR) begin
          w_state_nxt = RF_IDLE;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RF_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign o_idle       = (r_state == RF_IDLE);
  assign o_clr_busy   = r_busy;
  assign o_clr_done   = r_done;
  assign o_clear_we   = (r_state == RF_CLEAR);
  assign o_clear_addr = r_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: two registered read ports, one write port,
// optional write-to-read bypass, optional hardwired zero entry, bulk clear.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_DEF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEF_DEPTH,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rd_data1;
  logic [WIDTH-1:0]  r_rd_data2;
  logic              w_idle;
  logic              w_wr_accept;
  logic              w_clear_we;
  logic [ADDR_W-1:0] w_clear_addr;
  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [WIDTH-1:0]  w_rd_next [2];

  reg_file_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk          (clk),
    .rst          (rst),
    .i_clr_req    (bus.clr_req),
    .o_idle       (w_idle),
    .o_clr_busy   (bus.clr_busy),
    .o_clr_done   (bus.clr_done),
    .o_clear_we   (w_clear_we),
    .o_clear_addr (w_clear_addr)
  );

  assign w_wr_accept = rf_wr_accept(bus.wr_en, w_idle, 32'(bus.wr_addr),
                                    DEPTH, ZERO_REG);

  assign w_rd_addr[0] = bus.rd_addr1;
  assign w_rd_addr[1] = bus.rd_addr2;

  // Read value per port: zero for missing/hardwired entries, else the
  // forwarded write data (bypass) or the stored entry. Clears never forward.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd_next[p] = '0;
      if ((32'(w_rd_addr[p]) < DEPTH) && !(ZERO_REG && (w_rd_addr[p] == '0))) begin
        if (BYPASS && w_wr_accept && (w_rd_addr[p] == bus.wr_addr)) begin
          w_rd_next[p] = bus.wr_data;
        end else begin
          w_rd_next[p] = r_mem[w_rd_addr[p]];
        end
      end
    end
  end

  // Storage array: accepted writes, else the clear engine's zeroing write.
  // The two never coincide because writes are only accepted while idle.
  // NOTE: the array is reset explicitly because the CPU relies on every
  // register reading zero after reset; this keeps it in flops, not a RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_accept) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end else if (w_clear_we) begin
      r_mem[w_clear_addr] <= '0;
    end
  end

  // Registered read data; each port holds its value while its enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
    end else begin
      if (bus.rd_en1) r_rd_data1 <= w_rd_next[0];
      if (bus.rd_en2) r_rd_data2 <= w_rd_next[1];
    end
  end

  assign bus.rd_data1 = r_rd_data1;
  assign bus.rd_data2 = r_rd_data2;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: dut_a uses defaults (BYPASS=1, ZERO_REG=0, DEPTH=16);
// dut_b uses BYPASS=0, ZERO_REG=1, DEPTH=12.
module tb_reg_file_mp;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  reg_file_mp_if #(.WIDTH(32), .DEPTH(16)) bus_a ();
  reg_file_mp_if #(.WIDTH(32), .DEPTH(12)) bus_b ();

  reg_file_mp #(.WIDTH(32), .DEPTH(16), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  reg_file_mp #(.WIDTH(32), .DEPTH(12), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock, then settle 1 time unit past the rising edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.rd_addr1 = '0; bus_a.rd_en1 = 1'b0; bus_a.rd_addr2 = '0; bus_a.rd_en2 = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.clr_req = 1'b0;
    bus_b.rd_addr1 = '0; bus_b.rd_en1 = 1'b0; bus_b.rd_addr2 = '0; bus_b.rd_en2 = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) step();
    n_tests++; if (bus_a.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h exp 00000000", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h exp 00000000", bus_a.rd_data2); end
    n_tests++; if (bus_a.clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bus_a.clr_busy); end
    n_tests++; if (bus_a.clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bus_a.clr_done); end
    n_tests++; if (bus_b.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL reset_b_rd1: got %h exp 00000000", bus_b.rd_data1); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    for (int i = 1; i <= 4; i++) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'(i); bus_a.wr_data = 32'(i) * 32'h1111_1111;
      step();
    end
    bus_a.wr_en = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL wr_no_rd1: got %h exp 00000000", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL wr_no_rd2: got %h exp 00000000", bus_a.rd_data2); end
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd2;
    bus_a.rd_en2 = 1'b1; bus_a.rd_addr2 = 4'd4;
    step();
    bus_a.rd_en1 = 1'b0; bus_a.rd_en2 = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'h2222_2222) begin n_fail++; $display("FAIL read_a2: got %h exp 22222222", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h4444_4444) begin n_fail++; $display("FAIL read_a4: got %h exp 44444444", bus_a.rd_data2); end
  endtask

  task automatic test_read_enable();
    bus_a.rd_en1 = 1'b0; bus_a.rd_addr1 = 4'd1;
    bus_a.rd_en2 = 1'b1; bus_a.rd_addr2 = 4'd3;
    step();
    n_tests++; if (bus_a.rd_data1 !== 32'h2222_2222) begin n_fail++; $display("FAIL hold_rd1: got %h exp 22222222", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h3333_3333) begin n_fail++; $display("FAIL read_a3: got %h exp 33333333", bus_a.rd_data2); end
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd1;
    bus_a.rd_en2 = 1'b0; bus_a.rd_addr2 = 4'd2;
    step();
    n_tests++; if (bus_a.rd_data1 !== 32'h1111_1111) begin n_fail++; $display("FAIL read_a1: got %h exp 11111111", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h3333_3333) begin n_fail++; $display("FAIL hold_rd2: got %h exp 33333333", bus_a.rd_data2); end
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd4;
    bus_a.rd_en2 = 1'b1; bus_a.rd_addr2 = 4'd4;
    step();
    bus_a.rd_en1 = 1'b0; bus_a.rd_en2 = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'h4444_4444) begin n_fail++; $display("FAIL same_addr_rd1: got %h exp 44444444", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h4444_4444) begin n_fail++; $display("FAIL same_addr_rd2: got %h exp 44444444", bus_a.rd_data2); end
  endtask

  task automatic test_bypass();
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd3; bus_a.wr_data = 32'hDEAD_BEEF;
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd3;
    step();
    bus_a.wr_en = 1'b0; bus_a.rd_en1 = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_on: got %h exp deadbeef", bus_a.rd_data1); end
  endtask

  task automatic test_bypass_off();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd3; bus_b.wr_data = 32'h3333_3333;
    step();
    bus_b.wr_data = 32'hDEAD_BEEF;
    bus_b.rd_en1 = 1'b1; bus_b.rd_addr1 = 4'd3;
    step();
    bus_b.wr_en = 1'b0;
    n_tests++; if (bus_b.rd_data1 !== 32'h3333_3333) begin n_fail++; $display("FAIL bypass_off_old: got %h exp 33333333", bus_b.rd_data1); end
    step();
    bus_b.rd_en1 = 1'b0;
    n_tests++; if (bus_b.rd_data1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_off_new: got %h exp deadbeef", bus_b.rd_data1); end
  endtask

  task automatic test_zero_reg();
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd0; bus_b.wr_data = 32'hFFFF_FFFF;
    bus_b.rd_en2 = 1'b1; bus_b.rd_addr2 = 4'd0;
    step();
    bus_b.wr_en = 1'b0;
    n_tests++; if (bus_b.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL zero_reg_same: got %h exp 00000000", bus_b.rd_data2); end
    step();
    bus_b.rd_en2 = 1'b0;
    n_tests++; if (bus_b.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL zero_reg_read: got %h exp 00000000", bus_b.rd_data2); end
    bus_b.wr_en = 1'b1; bus_b.wr_addr = 4'd13; bus_b.wr_data = 32'h1313_1313;
    bus_b.rd_en1 = 1'b1; bus_b.rd_addr1 = 4'd13;
    step();
    n_tests++; if (bus_b.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL invalid_same: got %h exp 00000000", bus_b.rd_data1); end
    bus_b.rd_en1 = 1'b0;
    bus_b.wr_addr = 4'd11; bus_b.wr_data = 32'hBBBB_BBBB;
    step();
    bus_b.wr_en = 1'b0;
    bus_b.rd_en1 = 1'b1; bus_b.rd_addr1 = 4'd11;
    bus_b.rd_en2 = 1'b1; bus_b.rd_addr2 = 4'd13;
    step();
    bus_b.rd_en1 = 1'b0; bus_b.rd_en2 = 1'b0;
    n_tests++; if (bus_b.rd_data1 !== 32'hBBBB_BBBB) begin n_fail++; $display("FAIL last_entry: got %h exp bbbbbbbb", bus_b.rd_data1); end
    n_tests++; if (bus_b.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL invalid_read: got %h exp 00000000", bus_b.rd_data2); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < 16; i++) begin
      bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'(i); bus_a.wr_data = 32'hA000_0000 + 32'(i);
      step();
    end
    bus_a.wr_en = 1'b0;
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus_a.clr_busy !== 1'b1) break;
      busy_cnt++;
      case (c)
        2: bus_a.clr_req = 1'b1;
        3: bus_a.clr_req = 1'b0;
        8: begin
          bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd1; bus_a.wr_data = 32'h0000_0BAD;
          bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd1;
        end
        9: begin
          bus_a.wr_en = 1'b0; bus_a.rd_en1 = 1'b0;
          n_tests++; if (bus_a.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL busy_write_fwd: got %h exp 00000000", bus_a.rd_data1); end
          bus_a.rd_en2 = 1'b1; bus_a.rd_addr2 = 4'd9;
        end
        10: begin
          bus_a.rd_en2 = 1'b0;
          n_tests++; if (bus_a.rd_data2 !== 32'hA000_0009) begin n_fail++; $display("FAIL preclear_read: got %h exp a0000009", bus_a.rd_data2); end
        end
        default: ;
      endcase
      step();
    end
    n_tests++; if (busy_cnt !== 16) begin n_fail++; $display("FAIL busy_cycles: got %0d exp 16", busy_cnt); end
    n_tests++; if (bus_a.clr_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b exp 1", bus_a.clr_done); end
    step();
    n_tests++; if (bus_a.clr_done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b exp 0", bus_a.clr_done); end
    n_tests++; if (bus_a.clr_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b exp 0", bus_a.clr_busy); end
    for (int i = 0; i < 16; i++) begin
      bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'(i);
      step();
      n_tests++; if (bus_a.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL cleared_entry_%0d: got %h exp 00000000", i, bus_a.rd_data1); end
    end
    bus_a.rd_en1 = 1'b0;
  endtask

  task automatic test_restart_and_abort();
    int stray;
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd2; bus_a.wr_data = 32'h7777_7777;
    step();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd2;
    bus_a.rd_en2 = 1'b1; bus_a.rd_addr2 = 4'd2;
    step();
    bus_a.rd_en1 = 1'b0; bus_a.rd_en2 = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'h7777_7777) begin n_fail++; $display("FAIL pre_abort_rd1: got %h exp 77777777", bus_a.rd_data1); end
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.clr_done === 1'b1) break;
      step();
    end
    n_tests++; if (bus_a.clr_done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: got %b exp 1", bus_a.clr_done); end
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    n_tests++; if (bus_a.clr_busy !== 1'b1) begin n_fail++; $display("FAIL restart_in_done: got %b exp 1", bus_a.clr_busy); end
    repeat (5) step();
    rst = 1'b0;
    #1;
    n_tests++; if (bus_a.rd_data1 !== 32'h0) begin n_fail++; $display("FAIL abort_rd1: got %h exp 00000000", bus_a.rd_data1); end
    n_tests++; if (bus_a.rd_data2 !== 32'h0) begin n_fail++; $display("FAIL abort_rd2: got %h exp 00000000", bus_a.rd_data2); end
    n_tests++; if (bus_a.clr_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b exp 0", bus_a.clr_busy); end
    n_tests++; if (bus_a.clr_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b exp 0", bus_a.clr_done); end
    step();
    rst = 1'b1;
    stray = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus_a.clr_done !== 1'b0 || bus_a.clr_busy !== 1'b0) stray++;
    end
    n_tests++; if (stray !== 0) begin n_fail++; $display("FAIL post_abort_quiet: got %0d active cycles exp 0", stray); end
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 4'd7; bus_a.wr_data = 32'h5A5A_5A5A;
    step();
    bus_a.wr_en = 1'b0;
    bus_a.rd_en1 = 1'b1; bus_a.rd_addr1 = 4'd7;
    step();
    bus_a.rd_en1 = 1'b0;
    n_tests++; if (bus_a.rd_data1 !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL post_abort_rw: got %h exp 5a5a5a5a", bus_a.rd_data1); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_read_enable();
    test_bypass();
    test_bypass_off();
    test_zero_reg();
    test_clear();
    test_restart_and_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
